// File: rtl/xs128p_seq_gen_if.sv
// Port bundle between the memory-game controller (master) and the
// xorshift128+ sequence generator (slave).
interface xs128p_seq_gen_if #(
  parameter int SYM_W  = 2,
  parameter int ADDR_W = 5
);
  logic [63:0]       seed_x;
  logic [63:0]       seed_y;
  logic              seed_load;
  logic              clear;
  logic              gen_req;
  logic              gen_busy;
  logic              gen_done;
  logic [SYM_W-1:0]  gen_sym;
  logic [ADDR_W:0]   seq_len;
  logic              full;
  logic              seeded;
  logic [ADDR_W-1:0] rd_addr;
  logic [SYM_W-1:0]  rd_sym;
  logic [1:0]        dbg_state;

  // Request handshake: gen_req is a one-cycle pulse that is accepted only when
  // the generator is idle, seeded and not full; gen_busy is high from the cycle
  // after acceptance until the one-cycle gen_done pulse that completes it.
  modport master (
    output seed_x, seed_y, seed_load, clear, gen_req, rd_addr,
    input  gen_busy, gen_done, gen_sym, seq_len, full, seeded, rd_sym, dbg_state
  );

  modport slave (
    input  seed_x, seed_y, seed_load, clear, gen_req, rd_addr,
    output gen_busy, gen_done, gen_sym, seq_len, full, seeded, rd_sym, dbg_state
  );
endinterface

// File: rtl/xs128p_seq_gen.sv
// xorshift128+ symbol sequence generator with a registered random-access buffer.
// Optional macro SEQ_NO_REPEAT_EN: re-step (up to 3 times) to avoid consecutive repeats.
module xs128p_seq_gen #(
  parameter int SYM_W  = 2,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  xs128p_seq_gen_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    APPEND = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [63:0]       s0, s1;
  logic [63:0]       a_mix, step_s1;
  logic [SYM_W-1:0]  step_sym;
  logic [SYM_W-1:0]  cand_sym;
  logic [SYM_W-1:0]  gen_sym;
  logic [SYM_W-1:0]  rd_sym;
  logic [SYM_W-1:0]  seq_buf [DEPTH];
  logic [ADDR_W:0]   seq_len;
  logic              seeded;
  logic              gen_done;
  logic              full;
  logic              accept;
  logic              retry;
  logic [SYM_W-1:0]  next_cand;

  // Only the low bits of result = new_s1 + s1 are ever used.
  assign a_mix    = s0 ^ (s0 << 23);
  assign step_s1  = a_mix ^ s1 ^ (a_mix >> 17) ^ (s1 >> 26);
  assign step_sym = step_s1[SYM_W-1:0] + s1[SYM_W-1:0];

  assign full = (seq_len == (ADDR_W+1)'(DEPTH));

`ifdef SEQ_NO_REPEAT_EN
  logic [1:0]       retry_cnt;
  logic [SYM_W-1:0] last_sym;
  logic             repeat_hit;

  assign repeat_hit = (seq_len != '0) && (step_sym == last_sym);
  // After the third retry a persisting repeat is forced to the next symbol.
  assign next_cand  = repeat_hit ? step_sym + 1'b1 : step_sym;
`else
  assign next_cand  = step_sym;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    retry      = 1'b0;
    if (bus.seed_load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.gen_req && seeded && !full && !bus.clear) begin
            accept     = 1'b1;
            state_next = STEP;
          end
        end
        STEP: begin
`ifdef SEQ_NO_REPEAT_EN
          if (repeat_hit && retry_cnt != 2'd3) begin
            retry      = 1'b1;
            state_next = STEP;
          end else begin
            state_next = APPEND;
          end
`else
          state_next = APPEND;
`endif
        end
        APPEND:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0       <= '0;
      s1       <= '0;
      seeded   <= 1'b0;
      seq_len  <= '0;
      gen_done <= 1'b0;
      gen_sym  <= '0;
      cand_sym <= '0;
      rd_sym   <= '0;
`ifdef SEQ_NO_REPEAT_EN
      retry_cnt <= '0;
      last_sym  <= '0;
`endif
    end else begin
      gen_done <= 1'b0;
      rd_sym   <= ({1'b0, bus.rd_addr} < seq_len) ? seq_buf[bus.rd_addr] : '0;
      if (bus.seed_load) begin
        // The all-zero state would lock the generator at zero forever.
        s0      <= (bus.seed_x == '0 && bus.seed_y == '0) ? 64'd1 : bus.seed_x;
        s1      <= bus.seed_y;
        seeded  <= 1'b1;
        seq_len <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.clear) seq_len <= '0;
`ifdef SEQ_NO_REPEAT_EN
            if (accept) retry_cnt <= '0;
`endif
          end
          STEP: begin
            s0       <= s1;
            s1       <= step_s1;
            cand_sym <= next_cand;
`ifdef SEQ_NO_REPEAT_EN
            if (retry) retry_cnt <= retry_cnt + 2'd1;
`endif
          end
          APPEND: begin
            seq_len  <= seq_len + 1'b1;
            gen_sym  <= cand_sym;
            gen_done <= 1'b1;
`ifdef SEQ_NO_REPEAT_EN
            last_sym <= cand_sym;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Buffer has no reset; entries at or above seq_len are never returned.
  always_ff @(posedge clk) begin
    if (state == APPEND && !bus.seed_load)
      seq_buf[seq_len[ADDR_W-1:0]] <= cand_sym;
  end

  assign bus.gen_busy  = (state != IDLE);
  assign bus.gen_done  = gen_done;
  assign bus.gen_sym   = gen_sym;
  assign bus.seq_len   = seq_len;
  assign bus.full      = full;
  assign bus.seeded    = seeded;
  assign bus.rd_sym    = rd_sym;
  assign bus.dbg_state = state;

  logic unused_ok;
  assign unused_ok = ^{accept, retry};
endmodule
